pw_layer_sequencer: RTL and testbench
=====================================

# pw_layer_sequencer

Sequences one pointwise-convolution layer over a feature map by driving the non-pipelined `pointwise_conv_unit` one pixel at a time. For each pixel it fetches the IN_CH-channel input vector from the activation buffer and issues it to the unit. It then waits for the result and writes the OUT_CH-channel output vector to the output buffer with a ready/valid handshake. It sits between the layer-level control FSM (start/done) and the buffer memories.

## Interface
- IN_CH, 4, input channels per pixel (must match the conv unit)
- OUT_CH, 8, output channels per pixel (must match the conv unit)
- ACC_W, 32, bits per channel element on vectors
- ADDR_W, 16, buffer address width
- PIX_W, 16, pixel-count width
- TIMEOUT, 64, max cycles to wait for unit result
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  launch layer; sampled only in IDLE
- abort  in  1  synchronous abort; highest priority after reset
- cfg_num_pix  in  PIX_W  pixels to process; latched on start
- cfg_in_base  in  ADDR_W  input buffer base address; latched on start
- cfg_out_base  in  ADDR_W  output buffer base address; latched on start
- rd_en  out  1  input buffer read strobe
- rd_addr  out  ADDR_W  input buffer read address
- rd_data  in  IN_CH*ACC_W  read data, valid exactly 1 cycle after rd_en
- pw_i_valid  out  1  issue pulse to conv unit
- pw_i_vec_flat  out  IN_CH*ACC_W  vector to conv unit
- pw_o_valid  in  1  conv unit result pulse (1 cycle)
- pw_o_vec_flat  in  OUT_CH*ACC_W  conv unit result
- wr_valid  out  1  output write request
- wr_ready  in  1  output buffer accepts write
- wr_addr  out  ADDR_W  output write address
- wr_data  out  OUT_CH*ACC_W  output write data
- busy  out  1  high from start accept until return to IDLE
- done  out  1  one-cycle pulse on normal completion or timeout
- err  out  1  sticky timeout flag; cleared on next accepted start

## Operation
- States: IDLE, FETCH, RDWAIT, ISSUE, WAIT_PW, WRITE, FIN.
- IDLE: on start, latch cfg_*, clear pix counter and err, assert busy. If cfg_num_pix==0 go to FIN; otherwise go to FETCH.
- FETCH: rd_en=1, rd_addr=in_base+pix (mod 2^ADDR_W) -> RDWAIT.
- RDWAIT: register rd_data into pw_i_vec_flat -> ISSUE.
- ISSUE: pw_i_valid=1 for exactly one cycle. Clear the timeout counter -> WAIT_PW.
- WAIT_PW: on pw_o_valid, register pw_o_vec_flat into wr_data -> WRITE. Otherwise increment the timeout counter. When it reaches TIMEOUT, set err and go to FIN.
- WRITE: wr_valid=1, wr_addr=out_base+pix (mod 2^ADDR_W), wr_data held stable until wr_ready. On handshake, pix+1: if pix+1==num_pix go to FIN, else go to FETCH.
- FIN: done=1 for one cycle, busy drops -> IDLE.
- start outside IDLE is ignored. cfg_* changes after latching have no effect.
- abort in any non-IDLE state: go to IDLE next cycle, deassert all strobes, no done pulse, err unchanged.
- pw_o_valid outside WAIT_PW is ignored.
- The sequencer never issues a new vector before the previous result is written (the unit is not pipelined).

## Timing
- Reset values: rd_en, pw_i_valid, wr_valid, busy, done, err = 0. rd_addr, wr_addr, pw_i_vec_flat, wr_data = 0. State is IDLE.
- Start accepted in cycle 0: FETCH in cycle 1, ISSUE in cycle 3.
- With the conv unit's IN_CH+1-cycle result latency, the first wr_valid comes in cycle IN_CH+6 and wr_valid holds while wr_ready=0.
- Steady state with wr_ready=1: IN_CH+6 cycles per pixel.
- The done pulse comes 1 cycle after the last write handshake. For num_pix==0, done comes in cycle 2.
- All outputs are registered. No combinational path from inputs to outputs.

## Test plan
- Reset mid-layer: assert rst_n=0 during WAIT_PW -> all outputs 0 immediately, IDLE. A following start runs cleanly.
- num_pix=3, in_base=0x10, out_base=0x80, wr_ready=1, behavioural conv model -> reads at 0x10..0x12 and writes at 0x80..0x82 with correct dot products. Each pixel takes exactly 10 cycles (IN_CH=4). done is one pulse.
- Backpressure: hold wr_ready=0 for 5 cycles on pixel 1 -> wr_valid, wr_addr and wr_data stay stable, no extra rd_en, and total cycles increase by 5.
- num_pix=0 -> no rd_en or wr_valid, done in cycle 2. start while busy -> ignored.
- Model never returns pw_o_valid -> err=1 and done pulses TIMEOUT cycles after ISSUE. The next start clears err.
- Address wrap: in_base=0xFFFF, num_pix=2 -> reads at 0xFFFF then 0x0000. abort during WRITE -> IDLE with no done.

Source files
------------

// File: rtl/pw_layer_sequencer.sv
// Layer sequencer for the non-pipelined pointwise conv unit: fetch one pixel,
// issue it, wait for the result, write it out, repeat until the layer is done.
module pw_layer_sequencer #(
  parameter int unsigned IN_CH   = 4,
  parameter int unsigned OUT_CH  = 8,
  parameter int unsigned ACC_W   = 32,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned PIX_W   = 16,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  input  logic                    abort_i,
  input  logic [PIX_W-1:0]        cfg_num_pix_i,
  input  logic [ADDR_W-1:0]       cfg_in_base_i,
  input  logic [ADDR_W-1:0]       cfg_out_base_i,
  output logic                    rd_en_o,
  output logic [ADDR_W-1:0]       rd_addr_o,
  input  logic [IN_CH*ACC_W-1:0]  rd_data_i,
  output logic                    pw_i_valid_o,
  output logic [IN_CH*ACC_W-1:0]  pw_i_vec_flat_o,
  input  logic                    pw_o_valid_i,
  input  logic [OUT_CH*ACC_W-1:0] pw_o_vec_flat_i,
  output logic                    wr_valid_o,
  input  logic                    wr_ready_i,
  output logic [ADDR_W-1:0]       wr_addr_o,
  output logic [OUT_CH*ACC_W-1:0] wr_data_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o
);

  localparam int unsigned IN_W  = IN_CH * ACC_W;
  localparam int unsigned OUT_W = OUT_CH * ACC_W;
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_RDWAIT, S_ISSUE, S_WAIT_PW, S_WRITE, S_FIN
  } state_e;

  state_e            state_q, state_d;
  logic [PIX_W-1:0]  num_pix_q, num_pix_d;
  logic [PIX_W-1:0]  pix_q, pix_d;
  logic [ADDR_W-1:0] in_base_q, in_base_d;
  logic [ADDR_W-1:0] out_base_q, out_base_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              pw_i_valid_q, pw_i_valid_d;
  logic [IN_W-1:0]   pw_i_vec_q, pw_i_vec_d;
  logic              wr_valid_q, wr_valid_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [OUT_W-1:0]  wr_data_q, wr_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  // Next-state and next-output logic; outputs are computed for the state being entered.
  always_comb begin
    state_d      = state_q;
    num_pix_d    = num_pix_q;
    pix_d        = pix_q;
    in_base_d    = in_base_q;
    out_base_d   = out_base_q;
    tmo_d        = tmo_q;
    rd_en_d      = 1'b0;
    rd_addr_d    = rd_addr_q;
    pw_i_valid_d = 1'b0;
    pw_i_vec_d   = pw_i_vec_q;
    wr_valid_d   = wr_valid_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    err_d        = err_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          num_pix_d  = cfg_num_pix_i;
          in_base_d  = cfg_in_base_i;
          out_base_d = cfg_out_base_i;
          pix_d      = '0;
          err_d      = 1'b0;
          busy_d     = 1'b1;
          if (cfg_num_pix_i == '0) begin
            state_d = S_FIN;
          end else begin
            state_d   = S_FETCH;
            rd_en_d   = 1'b1;
            rd_addr_d = cfg_in_base_i;
          end
        end
      end
      S_FETCH: state_d = S_RDWAIT;
      S_RDWAIT: begin
        pw_i_vec_d   = rd_data_i;
        pw_i_valid_d = 1'b1;
        state_d      = S_ISSUE;
      end
      S_ISSUE: begin
        tmo_d   = '0;
        state_d = S_WAIT_PW;
      end
      S_WAIT_PW: begin
        if (pw_o_valid_i) begin
          wr_data_d  = pw_o_vec_flat_i;
          wr_valid_d = 1'b1;
          wr_addr_d  = out_base_q + ADDR_W'(pix_q);
          state_d    = S_WRITE;
        end else begin
          // Trip so that done lands exactly TIMEOUT cycles after the issue cycle.
          tmo_d = tmo_q + TMO_W'(1);
          if (tmo_d == TMO_W'(TIMEOUT - 1)) begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = S_FIN;
          end
        end
      end
      S_WRITE: begin
        if (wr_ready_i) begin
          wr_valid_d = 1'b0;
          pix_d      = pix_q + PIX_W'(1);
          if (pix_d == num_pix_q) begin
            done_d  = 1'b1;
            state_d = S_FIN;
          end else begin
            rd_en_d   = 1'b1;
            rd_addr_d = in_base_q + ADDR_W'(pix_d);
            state_d   = S_FETCH;
          end
        end
      end
      S_FIN: begin
        // An empty layer enters FIN without done set and raises it one cycle later.
        if (done_q) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          done_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort_i && (state_q != S_IDLE)) begin
      state_d      = S_IDLE;
      rd_en_d      = 1'b0;
      pw_i_valid_d = 1'b0;
      wr_valid_d   = 1'b0;
      busy_d       = 1'b0;
      done_d       = 1'b0;
      err_d        = err_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      num_pix_q    <= '0;
      pix_q        <= '0;
      in_base_q    <= '0;
      out_base_q   <= '0;
      tmo_q        <= '0;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      pw_i_valid_q <= 1'b0;
      pw_i_vec_q   <= '0;
      wr_valid_q   <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      num_pix_q    <= num_pix_d;
      pix_q        <= pix_d;
      in_base_q    <= in_base_d;
      out_base_q   <= out_base_d;
      tmo_q        <= tmo_d;
      rd_en_q      <= rd_en_d;
      rd_addr_q    <= rd_addr_d;
      pw_i_valid_q <= pw_i_valid_d;
      pw_i_vec_q   <= pw_i_vec_d;
      wr_valid_q   <= wr_valid_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign rd_en_o         = rd_en_q;
  assign rd_addr_o       = rd_addr_q;
  assign pw_i_valid_o    = pw_i_valid_q;
  assign pw_i_vec_flat_o = pw_i_vec_q;
  assign wr_valid_o      = wr_valid_q;
  assign wr_addr_o       = wr_addr_q;
  assign wr_data_o       = wr_data_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign err_o           = err_q;

endmodule

// File: tb/tb_pw_layer_sequencer.sv
// Bench for pw_layer_sequencer: activation memory and conv-unit models plus a
// scoreboard of expected read addresses and output writes.
module tb_pw_layer_sequencer;

  localparam int unsigned IN_CH   = 4;
  localparam int unsigned OUT_CH  = 8;
  localparam int unsigned ACC_W   = 32;
  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned PIX_W   = 16;
  localparam int unsigned TIMEOUT = 64;
  localparam int unsigned IN_W    = IN_CH * ACC_W;
  localparam int unsigned OUT_W   = OUT_CH * ACC_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start_i = 1'b0;
  logic              abort_i = 1'b0;
  logic [PIX_W-1:0]  cfg_num_pix = '0;
  logic [ADDR_W-1:0] cfg_in_base = '0;
  logic [ADDR_W-1:0] cfg_out_base = '0;
  logic              rd_en_o;
  logic [ADDR_W-1:0] rd_addr_o;
  logic [IN_W-1:0]   rd_data = '0;
  logic              pw_i_valid_o;
  logic [IN_W-1:0]   pw_i_vec_o;
  logic              pw_o_valid = 1'b0;
  logic [OUT_W-1:0]  pw_o_vec = '0;
  logic              wr_valid_o;
  logic              wr_ready = 1'b1;
  logic [ADDR_W-1:0] wr_addr_o;
  logic [OUT_W-1:0]  wr_data_o;
  logic              busy_o, done_o, err_o;

  pw_layer_sequencer #(
    .IN_CH(IN_CH), .OUT_CH(OUT_CH), .ACC_W(ACC_W),
    .ADDR_W(ADDR_W), .PIX_W(PIX_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
    .cfg_num_pix_i(cfg_num_pix), .cfg_in_base_i(cfg_in_base), .cfg_out_base_i(cfg_out_base),
    .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o), .rd_data_i(rd_data),
    .pw_i_valid_o(pw_i_valid_o), .pw_i_vec_flat_o(pw_i_vec_o),
    .pw_o_valid_i(pw_o_valid), .pw_o_vec_flat_i(pw_o_vec),
    .wr_valid_o(wr_valid_o), .wr_ready_i(wr_ready), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [OUT_W-1:0]  data;
  } wr_exp_t;

  logic [ADDR_W-1:0] exp_rd[$];
  wr_exp_t           exp_wr[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int t0 = 0;
  int rd_cnt, wr_cnt, done_cnt, first_wr, last_hs, done_cyc, stall_cnt;
  bit silent = 1'b0;

  function automatic logic [ACC_W-1:0] act(input logic [ADDR_W-1:0] a, input int i);
    return 32'(a) * 32'd3 + 32'(i) * 32'd1000 + 32'd1;
  endfunction

  function automatic logic [ACC_W-1:0] wgt(input int o, input int i);
    return 32'(o * int'(IN_CH) + i + 1);
  endfunction

  function automatic logic [OUT_W-1:0] conv(input logic [IN_W-1:0] v);
    logic [OUT_W-1:0] r;
    logic [ACC_W-1:0] acc;
    r = '0;
    for (int o = 0; o < int'(OUT_CH); o++) begin
      acc = '0;
      for (int i = 0; i < int'(IN_CH); i++) acc = acc + wgt(o, i) * v[i*ACC_W +: ACC_W];
      r[o*ACC_W +: ACC_W] = acc;
    end
    return r;
  endfunction

  function automatic logic [OUT_W-1:0] exp_out(input logic [ADDR_W-1:0] a);
    logic [OUT_W-1:0] r;
    logic [ACC_W-1:0] acc;
    r = '0;
    for (int o = 0; o < int'(OUT_CH); o++) begin
      acc = '0;
      for (int i = 0; i < int'(IN_CH); i++) acc = acc + wgt(o, i) * act(a, i);
      r[o*ACC_W +: ACC_W] = acc;
    end
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Activation buffer: data one cycle after rd_en.
  always @(posedge clk) begin
    if (rd_en_o)
      for (int i = 0; i < int'(IN_CH); i++) rd_data[i*ACC_W +: ACC_W] <= act(rd_addr_o, i);
  end

  // Conv unit: captures on issue, result pulse IN_CH+1 cycles after capture.
  logic [IN_W-1:0] cv_vec = '0;
  int cv_lat = 0;
  always @(posedge clk) begin
    pw_o_valid <= 1'b0;
    if (pw_i_valid_o) begin
      cv_vec <= pw_i_vec_o;
      cv_lat <= int'(IN_CH) + 1;
    end else if (cv_lat > 0) begin
      cv_lat <= cv_lat - 1;
      if (cv_lat == 1 && !silent) begin
        pw_o_valid <= 1'b1;
        pw_o_vec   <= conv(cv_vec);
      end
    end
  end

  // Scoreboard monitor.
  bit                prev_stall = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;
  logic [OUT_W-1:0]  prev_data = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_en_o) begin
        rd_cnt++;
        checks++;
        if (exp_rd.size() == 0) begin
          failures++;
          $display("FAIL rd_unexpected: rd_en at addr %h, none expected", rd_addr_o);
        end else begin
          logic [ADDR_W-1:0] ea;
          ea = exp_rd.pop_front();
          if (rd_addr_o !== ea) begin
            failures++;
            $display("FAIL rd_addr: got %h expected %h", rd_addr_o, ea);
          end
        end
      end
      if (wr_valid_o) begin
        if (first_wr < 0) first_wr = cyc - t0;
        if (prev_stall) begin
          checks++;
          if (wr_addr_o !== prev_addr || wr_data_o !== prev_data) begin
            failures++;
            $display("FAIL wr_hold: addr %h data %h changed from %h %h", wr_addr_o, wr_data_o, prev_addr, prev_data);
          end
        end
        if (!wr_ready) stall_cnt++;
        else begin
          wr_cnt++;
          last_hs = cyc - t0;
          checks++;
          if (exp_wr.size() == 0) begin
            failures++;
            $display("FAIL wr_unexpected: write at addr %h, none expected", wr_addr_o);
          end else begin
            wr_exp_t e;
            e = exp_wr.pop_front();
            if (wr_addr_o !== e.addr || wr_data_o !== e.data) begin
              failures++;
              $display("FAIL wr_xact: got %h/%h expected %h/%h", wr_addr_o, wr_data_o, e.addr, e.data);
            end
          end
        end
      end
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc - t0;
      end
    end
    prev_stall = wr_valid_o && !wr_ready;
    prev_addr  = wr_addr_o;
    prev_data  = wr_data_o;
  end

  // Pushes expectations, pulses start for cycle 0, then scrambles cfg.
  task automatic start_layer(input int n, input logic [ADDR_W-1:0] ib, input logic [ADDR_W-1:0] ob,
                             input int nrd, input int nwr);
    wr_exp_t e;
    for (int i = 0; i < nrd; i++) exp_rd.push_back(ib + ADDR_W'(i));
    for (int i = 0; i < nwr; i++) begin
      e.addr = ob + ADDR_W'(i);
      e.data = exp_out(ib + ADDR_W'(i));
      exp_wr.push_back(e);
    end
    @(posedge clk); #1;
    rd_cnt = 0; wr_cnt = 0; done_cnt = 0; stall_cnt = 0;
    first_wr = -1; last_hs = -1; done_cyc = -1;
    t0 = cyc;
    start_i = 1'b1; cfg_num_pix = PIX_W'(n); cfg_in_base = ib; cfg_out_base = ob;
    @(posedge clk); #1;
    start_i = 1'b0; cfg_num_pix = 16'hBEEF; cfg_in_base = 16'h1234; cfg_out_base = 16'h4321;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (!busy_o) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    logic [5:0] strobes;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    strobes = {rd_en_o, pw_i_valid_o, wr_valid_o, busy_o, done_o, err_o};
    checks++;
    if (strobes !== 6'b0) begin failures++; $display("FAIL reset_strobes: got %b expected 000000", strobes); end
    checks++;
    if ({rd_addr_o, wr_addr_o} !== '0 || pw_i_vec_o !== '0 || wr_data_o !== '0) begin
      failures++; $display("FAIL reset_data: rd_addr %h wr_addr %h not all zero", rd_addr_o, wr_addr_o);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy_o !== 1'b0) begin failures++; $display("FAIL idle_busy: got %b expected 0", busy_o); end
  endtask

  task automatic test_basic;
    bit ok;
    start_layer(3, 16'h0010, 16'h0080, 3, 3);
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b1 || rd_en_o !== 1'b1) begin
      failures++; $display("FAIL basic_cycle1: busy %b rd_en %b expected 1 1", busy_o, rd_en_o);
    end
    wait_idle(100, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL basic_timeout: busy still %b", busy_o); end
    checks++;
    if (first_wr != int'(IN_CH) + 6) begin failures++; $display("FAIL basic_first_wr: got %0d expected %0d", first_wr, IN_CH + 6); end
    checks++;
    if (last_hs != 30 || done_cyc != 31) begin
      failures++; $display("FAIL basic_timing: last_hs %0d done %0d expected 30 31", last_hs, done_cyc);
    end
    checks++;
    if (done_cnt != 1 || rd_cnt != 3 || wr_cnt != 3) begin
      failures++; $display("FAIL basic_counts: done %0d rd %0d wr %0d expected 1 3 3", done_cnt, rd_cnt, wr_cnt);
    end
    checks++;
    if (exp_rd.size() != 0 || exp_wr.size() != 0) begin
      failures++; $display("FAIL basic_left: rd %0d wr %0d expected 0 0", exp_rd.size(), exp_wr.size());
    end
  endtask

  task automatic test_reset_mid;
    logic [5:0] strobes;
    start_layer(1, 16'h0200, 16'h0300, 1, 1);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    strobes = {rd_en_o, pw_i_valid_o, wr_valid_o, busy_o, done_o, err_o};
    checks++;
    if (strobes !== 6'b0 || pw_i_vec_o !== '0 || rd_addr_o !== '0) begin
      failures++; $display("FAIL reset_mid: strobes %b rd_addr %h expected all zero", strobes, rd_addr_o);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_rd.delete();
    exp_wr.delete();
    repeat (10) @(posedge clk);
    checks++;
    if (busy_o !== 1'b0 || wr_valid_o !== 1'b0) begin
      failures++; $display("FAIL reset_mid_idle: busy %b wr_valid %b expected 0 0", busy_o, wr_valid_o);
    end
  endtask

  task automatic test_backpressure;
    bit fin;
    int rel;
    fin = 1'b0;
    start_layer(3, 16'h0010, 16'h0080, 3, 3);
    for (int k = 0; k < 200 && !fin; k++) begin
      @(posedge clk); #1;
      rel = cyc - t0;
      wr_ready = !(rel >= 20 && rel <= 24);
      @(negedge clk);
      if (!busy_o) fin = 1'b1;
    end
    wr_ready = 1'b1;
    checks++;
    if (!fin) begin failures++; $display("FAIL bp_timeout: busy still %b", busy_o); end
    checks++;
    if (stall_cnt != 5) begin failures++; $display("FAIL bp_stall: got %0d expected 5", stall_cnt); end
    checks++;
    if (last_hs != 35 || done_cyc != 36) begin
      failures++; $display("FAIL bp_timing: last_hs %0d done %0d expected 35 36", last_hs, done_cyc);
    end
    checks++;
    if (rd_cnt != 3 || wr_cnt != 3 || done_cnt != 1) begin
      failures++; $display("FAIL bp_counts: rd %0d wr %0d done %0d expected 3 3 1", rd_cnt, wr_cnt, done_cnt);
    end
  endtask

  task automatic test_zero_and_ignore;
    bit ok;
    start_layer(0, 16'h0040, 16'h0050, 0, 0);
    wait_idle(20, ok);
    checks++;
    if (!ok || done_cyc != 2 || done_cnt != 1) begin
      failures++; $display("FAIL zero_done: ok %b done_cyc %0d cnt %0d expected 1 2 1", ok, done_cyc, done_cnt);
    end
    checks++;
    if (rd_cnt != 0 || first_wr != -1) begin
      failures++; $display("FAIL zero_traffic: rd %0d first_wr %0d expected 0 -1", rd_cnt, first_wr);
    end
    start_layer(1, 16'h0030, 16'h0050, 1, 1);
    repeat (3) @(posedge clk);
    #1;
    start_i = 1'b1; cfg_num_pix = 16'd4; cfg_in_base = 16'h0070; cfg_out_base = 16'h0090;
    @(posedge clk); #1 start_i = 1'b0;
    wait_idle(100, ok);
    repeat (15) @(negedge clk);
    checks++;
    if (!ok || rd_cnt != 1 || wr_cnt != 1 || done_cnt != 1) begin
      failures++; $display("FAIL ignore_start: ok %b rd %0d wr %0d done %0d expected 1 1 1 1", ok, rd_cnt, wr_cnt, done_cnt);
    end
  endtask

  task automatic test_timeout;
    bit ok;
    silent = 1'b1;
    start_layer(2, 16'h0100, 16'h0180, 1, 0);
    wait_idle(200, ok);
    silent = 1'b0;
    checks++;
    if (!ok || done_cyc != 3 + int'(TIMEOUT) || done_cnt != 1) begin
      failures++; $display("FAIL tmo_done: ok %b done_cyc %0d cnt %0d expected 1 %0d 1", ok, done_cyc, done_cnt, 3 + TIMEOUT);
    end
    checks++;
    if (err_o !== 1'b1 || wr_cnt != 0) begin failures++; $display("FAIL tmo_err: err %b wr %0d expected 1 0", err_o, wr_cnt); end
    start_layer(1, 16'h0005, 16'h0006, 1, 1);
    @(negedge clk);
    checks++;
    if (err_o !== 1'b0) begin failures++; $display("FAIL tmo_clear: err %b expected 0", err_o); end
    wait_idle(100, ok);
    checks++;
    if (!ok || wr_cnt != 1 || err_o !== 1'b0) begin
      failures++; $display("FAIL tmo_rerun: ok %b wr %0d err %b expected 1 1 0", ok, wr_cnt, err_o);
    end
  endtask

  task automatic test_wrap_abort;
    bit ok;
    bit seen;
    start_layer(2, 16'hFFFF, 16'hFFFF, 2, 2);
    wait_idle(100, ok);
    checks++;
    if (!ok || rd_cnt != 2 || wr_cnt != 2 || done_cnt != 1) begin
      failures++; $display("FAIL wrap: ok %b rd %0d wr %0d done %0d expected 1 2 2 1", ok, rd_cnt, wr_cnt, done_cnt);
    end
    wr_ready = 1'b0;
    start_layer(2, 16'h0020, 16'h0040, 1, 0);
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (wr_valid_o) seen = 1'b1;
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL abort_no_write: wr_valid %b expected 1", wr_valid_o); end
    @(posedge clk); #1 abort_i = 1'b1;
    @(posedge clk); #1 abort_i = 1'b0;
    @(negedge clk);
    checks++;
    if (wr_valid_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0 || err_o !== 1'b0) begin
      failures++; $display("FAIL abort_idle: wr_valid %b busy %b done %b err %b expected 0 0 0 0", wr_valid_o, busy_o, done_o, err_o);
    end
    wr_ready = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (done_cnt != 0 || rd_cnt != 1 || wr_cnt != 0) begin
      failures++; $display("FAIL abort_after: done %0d rd %0d wr %0d expected 0 1 0", done_cnt, rd_cnt, wr_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reset_mid();
    test_basic();
    test_backpressure();
    test_zero_and_ignore();
    test_timeout();
    test_wrap_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule
